// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eq_pkg
//  Purpose  : Shared constants and helper functions for the stereo EQ mixer:
//             FSM state encodings, Q-format unity gain, saturation limits and
//             accumulator width.
//  Revision : 1.0  initial release
// ============================================================================
package eq_pkg;

  // Mixer FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for an input sample
  localparam logic [1:0] ST_ACC  = 2'd1;  // one MAC per term per cycle
  localparam logic [1:0] ST_SAT  = 2'd2;  // round / saturate / clip detect
  localparam logic [1:0] ST_HOLD = 2'd3;  // load output register when free

  // Unity gain in a signed gain format with 'frac' fractional bits
  function automatic longint gain_one(input int frac);
    return longint'(1) <<< frac;
  endfunction

  // Largest positive value of a signed w-bit sample
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  // Most negative value of a signed w-bit sample
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Full-precision accumulator width for dry + n_bands products
  function automatic int acc_w(input int data_w, input int gain_w, input int n_bands);
    return data_w + gain_w + $clog2(n_bands + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eq_mac_channel.sv
`default_nettype none
// ============================================================================
//  Module   : eq_mac_channel
//  Purpose  : One audio channel of the EQ mixer. Accumulates sample*gain
//             products at full precision, then rounds half up, saturates to
//             DATA_W and flags a clip.
//  Ports    : aclk/resetn  clock, async active-low reset
//             clear        zero the accumulator (start of a new sample)
//             enable       add sample*gain into the accumulator
//             latch        register rounded/saturated result and clip flag
//             sample, gain current term operands (signed)
//             result, clip registered mixer result and its clip flag
//  Revision : 1.0  initial release
// ============================================================================
module eq_mac_channel
  import eq_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 12,
  parameter int ACC_W     = 43
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     latch,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [GAIN_W-1:0] gain,
  output logic        [DATA_W-1:0] result,
  output logic                     clip
);

  localparam int PROD_W = DATA_W + GAIN_W;
  // One guard bit so adding the rounding constant can never wrap
  localparam int SH_W   = ACC_W + 1;

  localparam logic signed [SH_W-1:0] RND_HALF = SH_W'(longint'(1) <<< (GAIN_FRAC - 1));
  localparam logic signed [SH_W-1:0] SAT_HI   = SH_W'(sat_max(DATA_W));
  localparam logic signed [SH_W-1:0] SAT_LO   = SH_W'(sat_min(DATA_W));

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [SH_W-1:0]   rnd_sum;
  logic signed [SH_W-1:0]   rnd_shr;
  logic [DATA_W-1:0]        result_q, result_d;
  logic                     clip_q, clip_d;

  assign prod = sample * gain;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (enable) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Round half up, then drop the gain fraction with an arithmetic shift
    rnd_sum = {acc_q[ACC_W-1], acc_q} + RND_HALF;
    rnd_shr = rnd_sum >>> GAIN_FRAC;

    result_d = result_q;
    clip_d   = clip_q;
    if (latch) begin
      if (rnd_shr > SAT_HI) begin
        result_d = SAT_HI[DATA_W-1:0];
        clip_d   = 1'b1;
      end else if (rnd_shr < SAT_LO) begin
        result_d = SAT_LO[DATA_W-1:0];
        clip_d   = 1'b1;
      end else begin
        result_d = rnd_shr[DATA_W-1:0];
        clip_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      result_q <= '0;
      clip_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      result_q <= result_d;
      clip_q   <= clip_d;
    end
  end

  assign result = result_q;
  assign clip   = clip_q;

endmodule
`default_nettype wire

// File: rtl/axis_eq_mixer_v1_0.sv
`default_nettype none
// ============================================================================
//  Module   : axis_eq_mixer_v1_0
//  Purpose  : N-band stereo equalizer mixer. Output = round/saturate of
//             dry*gain_dry + sum(band_k*gain_band_k), per channel, with
//             AXI-Stream handshakes on both sides, bypass and clip counter.
//  Ports    : aclk, resetn                 clock, async active-low reset
//             s_axis_tdata   {L,R} dry     s_axis_band_tdata  band k {L,R}
//             s_axis_tlast/tvalid/tready   input stream handshake
//             gain_dry, gain_band          signed gains (captured on accept)
//             bypass                       1: output = dry sample unchanged
//             m_axis_tdata/tlast/tvalid/tready  output stream
//             sat_count / sat_clear        clipped-sample counter and clear
//  Revision : 1.0  initial release
// ============================================================================
module axis_eq_mixer_v1_0
  import eq_pkg::*;
#(
  parameter int N_BANDS   = 4,
  parameter int DATA_W    = 24,
  parameter int GAIN_W    = 16,
  parameter int GAIN_FRAC = 12,
  parameter int SATCNT_W  = 16
) (
  input  logic                          aclk,
  input  logic                          resetn,
  input  logic [2*DATA_W-1:0]           s_axis_tdata,
  input  logic [2*N_BANDS*DATA_W-1:0]   s_axis_band_tdata,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [GAIN_W-1:0]             gain_dry,
  input  logic [N_BANDS*GAIN_W-1:0]     gain_band,
  input  logic                          bypass,
  output logic [2*DATA_W-1:0]           m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [SATCNT_W-1:0]           sat_count,
  input  logic                          sat_clear
);

  localparam int ACC_W = acc_w(DATA_W, GAIN_W, N_BANDS);
  localparam int IDX_W = $clog2(N_BANDS + 1);

  logic [1:0]                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [2*DATA_W-1:0]           dry_q, dry_d;
  logic [2*N_BANDS*DATA_W-1:0]   band_q, band_d;
  logic                          last_q, last_d;
  logic                          bypass_q, bypass_d;
  logic [GAIN_W-1:0]             gdry_q, gdry_d;
  logic [N_BANDS*GAIN_W-1:0]     gband_q, gband_d;
  logic [2*DATA_W-1:0]           out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;
  logic                          out_valid_q, out_valid_d;
  logic [SATCNT_W-1:0]           sat_count_q, sat_count_d;

  logic                          out_free;
  logic                          mac_clear, mac_en, mac_latch, sat_inc;
  logic [DATA_W-1:0]             term_l, term_r;
  logic [GAIN_W-1:0]             term_gain;
  logic [DATA_W-1:0]             res_l, res_r;
  logic                          clip_l, clip_r;

  assign out_free = !out_valid_q || m_axis_tready;

  // Term 0 is the dry sample; term k (1..N_BANDS) is band k-1
  always_comb begin
    term_l    = dry_q[2*DATA_W-1 -: DATA_W];
    term_r    = dry_q[DATA_W-1:0];
    term_gain = gdry_q;
    for (int k = 0; k < N_BANDS; k++) begin
      if (idx_q == IDX_W'(k + 1)) begin
        term_l    = band_q[k*2*DATA_W + DATA_W +: DATA_W];
        term_r    = band_q[k*2*DATA_W +: DATA_W];
        term_gain = gband_q[k*GAIN_W +: GAIN_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dry_d       = dry_q;
    band_d      = band_q;
    last_d      = last_q;
    bypass_d    = bypass_q;
    gdry_d      = gdry_q;
    gband_d     = gband_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    mac_clear   = 1'b0;
    mac_en      = 1'b0;
    mac_latch   = 1'b0;
    sat_inc     = 1'b0;

    // Handshake drains the output; a load below in the same cycle overrides
    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          dry_d     = s_axis_tdata;
          band_d    = s_axis_band_tdata;
          last_d    = s_axis_tlast;
          bypass_d  = bypass;
          gdry_d    = gain_dry;
          gband_d   = gain_band;
          mac_clear = 1'b1;
          idx_d     = '0;
          state_d   = ST_ACC;
        end
      end
      ST_ACC: begin
        mac_en = 1'b1;
        if (idx_q == IDX_W'(N_BANDS)) begin
          state_d = ST_SAT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_SAT: begin
        // Result is registered inside the MAC channels here; the output
        // register picks it up in HOLD (same cycle when unstalled).
        mac_latch = 1'b1;
        state_d   = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_free) begin
          out_data_d  = bypass_q ? dry_q : {res_l, res_r};
          out_last_d  = last_q;
          out_valid_d = 1'b1;
          sat_inc     = !bypass_q && (clip_l || clip_r);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (sat_inc && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + SATCNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      dry_q       <= '0;
      band_q      <= '0;
      last_q      <= 1'b0;
      bypass_q    <= 1'b0;
      gdry_q      <= '0;
      gband_q     <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      sat_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dry_q       <= dry_d;
      band_q      <= band_d;
      last_q      <= last_d;
      bypass_q    <= bypass_d;
      gdry_q      <= gdry_d;
      gband_q     <= gband_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      sat_count_q <= sat_count_d;
    end
  end

  eq_mac_channel #(
    .DATA_W    (DATA_W),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac_l (
    .aclk   (aclk),
    .resetn (resetn),
    .clear  (mac_clear),
    .enable (mac_en),
    .latch  (mac_latch),
    .sample (term_l),
    .gain   (term_gain),
    .result (res_l),
    .clip   (clip_l)
  );

  eq_mac_channel #(
    .DATA_W    (DATA_W),
    .GAIN_W    (GAIN_W),
    .GAIN_FRAC (GAIN_FRAC),
    .ACC_W     (ACC_W)
  ) u_mac_r (
    .aclk   (aclk),
    .resetn (resetn),
    .clear  (mac_clear),
    .enable (mac_en),
    .latch  (mac_latch),
    .sample (term_r),
    .gain   (term_gain),
    .result (res_r),
    .clip   (clip_r)
  );

  assign s_axis_tready = (state_q == ST_IDLE);
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;
  assign sat_count     = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_eq_mixer_v1_0.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_eq_mixer_v1_0
//  Purpose  : Directed self-checking bench for axis_eq_mixer_v1_0
//             (N_BANDS=4, DATA_W=24, gains Q4.12).
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_eq_mixer_v1_0;

  localparam int NB = 4;
  localparam int DW = 24;
  localparam int GW = 16;

  logic              aclk = 1'b0;
  logic              resetn = 1'b0;
  logic [2*DW-1:0]   s_axis_tdata = '0;
  logic [2*NB*DW-1:0] s_axis_band_tdata = '0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [GW-1:0]     gain_dry = '0;
  logic [NB*GW-1:0]  gain_band = '0;
  logic              bypass = 1'b0;
  logic [2*DW-1:0]   m_axis_tdata;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [15:0]       sat_count;
  logic              sat_clear = 1'b0;

  int checks   = 0;
  int failures = 0;

  axis_eq_mixer_v1_0 dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_band_tdata (s_axis_band_tdata),
    .s_axis_tlast      (s_axis_tlast),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .gain_dry          (gain_dry),
    .gain_band         (gain_band),
    .bypass            (bypass),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_tlast      (m_axis_tlast),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .sat_count         (sat_count),
    .sat_clear         (sat_clear)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*NB*DW-1:0] pack_bands(input logic [47:0] b0, input logic [47:0] b1,
                                                    input logic [47:0] b2, input logic [47:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  function automatic logic [NB*GW-1:0] pack_gains(input logic [15:0] g0, input logic [15:0] g1,
                                                  input logic [15:0] g2, input logic [15:0] g3);
    return {g3, g2, g1, g0};
  endfunction

  // Present a sample and return 1 time unit after the accepting edge
  task automatic send(input logic [47:0] dry, input logic [2*NB*DW-1:0] bands, input logic last);
    int n;
    n = 0;
    s_axis_tdata      = dry;
    s_axis_band_tdata = bands;
    s_axis_tlast      = last;
    s_axis_tvalid     = 1'b1;
    while (!s_axis_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("accept_ready", 64'(s_axis_tready), 64'd1);
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  // Count edges from the accept edge until tvalid is seen (bounded)
  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(posedge aclk);
      #1;
      cyc++;
    end while (!m_axis_tvalid && cyc < 60);
  endtask

  task automatic drain();
    @(posedge aclk);
    #1;
  endtask

  logic [48:0] got_q[3];
  int          got;
  int          lat;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge aclk);
    check("rst_tready", 64'(s_axis_tready), 64'd1);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata",  64'(m_axis_tdata),  64'd0);
    check("rst_tlast",  64'(m_axis_tlast),  64'd0);
    check("rst_satcnt", 64'(sat_count),     64'd0);
    resetn = 1'b1;
    @(negedge aclk);

    // ---------------- 1: unity band0 ----------------
    gain_dry  = 16'h0000;
    gain_band = pack_gains(16'h1000, 16'h0000, 16'h0000, 16'h0000);
    send({24'h111111, 24'h222222},
         pack_bands({24'h200000, 24'hE00000}, 48'h050505_050505, 48'h050505_050505, 48'h050505_050505),
         1'b1);
    wait_out(lat);
    check("t1_latency", 64'(lat), 64'd7);
    check("t1_data",    64'(m_axis_tdata), 64'h200000_E00000);
    check("t1_tlast",   64'(m_axis_tlast), 64'd1);
    check("t1_satcnt",  64'(sat_count),    64'd0);
    drain();
    check("t1_tvalid_drop", 64'(m_axis_tvalid), 64'd0);

    // ---------------- multi-band weighted sum ----------------
    gain_dry  = 16'h0400;
    gain_band = pack_gains(16'h0000, 16'h2000, 16'hF000, 16'h1000);
    send({24'h100000, 24'hF00000},
         pack_bands({24'h7FFFFF, 24'h7FFFFF}, {24'h010000, 24'h000000},
                    {24'h001000, 24'h000010}, {24'h000100, 24'h000001}),
         1'b0);
    wait_out(lat);
    check("mb_data",  64'(m_axis_tdata), 64'h05F100_FBFFF1);
    check("mb_tlast", 64'(m_axis_tlast), 64'd0);
    drain();

    // ---------------- 2: clip ----------------
    gain_dry  = 16'h1000;
    gain_band = pack_gains(16'h1000, 16'h0000, 16'h0000, 16'h0000);
    send({24'h600000, 24'hA00000},
         pack_bands({24'h600000, 24'hA00000}, 48'd0, 48'd0, 48'd0), 1'b0);
    wait_out(lat);
    check("t2_data",   64'(m_axis_tdata), 64'h7FFFFF_800000);
    check("t2_satcnt", 64'(sat_count),    64'd1);
    drain();
    send({24'h600000, 24'hA00000},
         pack_bands({24'h600000, 24'hA00000}, 48'd0, 48'd0, 48'd0), 1'b0);
    repeat (6) @(posedge aclk);
    #1;
    check("t2b_not_yet", 64'(m_axis_tvalid), 64'd0);
    sat_clear = 1'b1;
    @(posedge aclk);
    #1;
    sat_clear = 1'b0;
    check("t2b_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("t2b_data",   64'(m_axis_tdata),  64'h7FFFFF_800000);
    check("t2b_clear_wins", 64'(sat_count), 64'd0);
    drain();

    // ---------------- 4: gain timing ----------------
    gain_dry  = 16'h0000;
    gain_band = pack_gains(16'h1000, 16'h0000, 16'h0000, 16'h0000);
    send(48'd0, pack_bands({24'h400000, 24'h100000}, 48'd0, 48'd0, 48'd0), 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    gain_band = pack_gains(16'h0800, 16'h0000, 16'h0000, 16'h0000);
    wait_out(lat);
    check("t4_old_gain", 64'(m_axis_tdata), 64'h400000_100000);
    drain();
    send(48'd0, pack_bands({24'h400000, 24'hFFFFFD}, 48'd0, 48'd0, 48'd0), 1'b0);
    wait_out(lat);
    check("t4_new_gain_round", 64'(m_axis_tdata), 64'h200000_FFFFFF);
    drain();

    // ---------------- 5: bypass ----------------
    bypass    = 1'b1;
    gain_dry  = 16'h7FFF;
    gain_band = pack_gains(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    send({24'h123456, 24'hFEDCBA},
         pack_bands(48'h700000_700000, 48'h700000_700000, 48'h700000_700000, 48'h700000_700000),
         1'b1);
    @(posedge aclk);
    #1;
    bypass = 1'b0;  // must not affect the captured sample
    wait_out(lat);
    check("t5_latency", 64'(lat + 1), 64'd7);
    check("t5_data",    64'(m_axis_tdata), 64'h123456_FEDCBA);
    check("t5_satcnt",  64'(sat_count),    64'd0);
    drain();

    // ---------------- 3: backpressure ----------------
    gain_dry      = 16'h1000;
    gain_band     = '0;
    m_axis_tready = 1'b0;
    send({24'h000001, 24'h000011}, '0, 1'b0);
    wait_out(lat);
    check("t3_first_valid", 64'(m_axis_tvalid), 64'd1);
    send({24'h000002, 24'h000012}, '0, 1'b1);
    repeat (12) @(posedge aclk);
    #1;
    check("t3_tready_held", 64'(s_axis_tready), 64'd0);
    check("t3_stable",      64'(m_axis_tdata),  64'h000001_000011);
    m_axis_tready = 1'b1;
    got = 0;
    fork
      send({24'h000003, 24'h000013}, '0, 1'b0);
      begin
        int n;
        n = 0;
        while (got < 3 && n < 80) begin
          @(negedge aclk);
          n++;
          if (m_axis_tvalid) begin
            got_q[got] = {m_axis_tlast, m_axis_tdata};
            got++;
          end
        end
      end
    join
    check("t3_count", 64'(got), 64'd3);
    check("t3_out0", 64'(got_q[0]), {15'd0, 1'b0, 48'h000001_000011});
    check("t3_out1", 64'(got_q[1]), {15'd0, 1'b1, 48'h000002_000012});
    check("t3_out2", 64'(got_q[2]), {15'd0, 1'b0, 48'h000003_000013});
    drain();
    check("t3_idle_after", 64'(m_axis_tvalid), 64'd0);

    // ---------------- 6: async reset mid-ACC ----------------
    m_axis_tready = 1'b0;
    gain_band     = pack_gains(16'h1000, 16'h0000, 16'h0000, 16'h0000);
    send({24'h600000, 24'hA00000},
         pack_bands({24'h600000, 24'hA00000}, 48'd0, 48'd0, 48'd0), 1'b0);
    wait_out(lat);
    check("t6_pre_satcnt", 64'(sat_count), 64'd1);
    send({24'h000100, 24'h000200}, '0, 1'b0);
    repeat (2) @(posedge aclk);
    #2;
    resetn = 1'b0;
    #1;
    check("t6_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_rst_tdata",  64'(m_axis_tdata),  64'd0);
    check("t6_rst_satcnt", 64'(sat_count),     64'd0);
    check("t6_rst_tready", 64'(s_axis_tready), 64'd1);
    @(negedge aclk);
    resetn        = 1'b1;
    m_axis_tready = 1'b1;
    gain_dry      = 16'h0000;
    @(negedge aclk);
    send({24'h111111, 24'h222222},
         pack_bands({24'h200000, 24'hE00000}, 48'd0, 48'd0, 48'd0), 1'b1);
    wait_out(lat);
    check("t6_post_latency", 64'(lat), 64'd7);
    check("t6_post_data",    64'(m_axis_tdata), 64'h200000_E00000);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
